// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-scanned key matrix with frame-level debounce,
// ascending-order press/release event emitter and a small event FIFO.
`timescale 1ns/1ps
module keypad_matrix_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4,
    localparam int KW = $clog2(ROWS * COLS)
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic [COLS-1:0]      col,
    output logic [ROWS-1:0]      row,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KW-1:0]        evt_code,
    output logic                 evt_press,
    output logic                 overflow,
    input  logic                 ovf_clr
);
    localparam int N  = ROWS * COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, EMIT} emit_t;

    logic [DW-1:0]   div_cnt;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_idx_nxt;
    logic [ROWS-1:0] row_nxt;
    logic [N-1:0]    snap;
    logic [N-1:0]    snap_nxt;
    logic [N-1:0]    prev;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_nxt;
    logic [N-1:0]    diff;
    emit_t           state;
    logic [KW-1:0]   emit_idx;
    logic            tick;
    logic            frame_end;
    logic            commit;
    logic            push;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;
    logic [KW:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;

    assign tick        = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_end   = tick && (row_idx == RW'(ROWS - 1));
    assign row_idx_nxt = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);

    // Merge the current column sample into the snapshot; one-hot of next row
    always_comb begin
        snap_nxt = snap;
        row_nxt  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (RW'(r) == row_idx) snap_nxt[r*COLS +: COLS] = col;
            if (RW'(r) == row_idx_nxt) row_nxt[r] = 1'b1;
        end
    end

    // Stability counter update for a completed frame
    always_comb begin
        if (snap_nxt != prev)
            stable_nxt = '0;
        else if (stable_cnt == SW'(DEBOUNCE_FRAMES))
            stable_nxt = stable_cnt;
        else
            stable_nxt = stable_cnt + SW'(1);
    end

    assign commit = frame_end
                 && (stable_nxt == SW'(DEBOUNCE_FRAMES))
                 && (snap_nxt != key_state)
                 && (state == IDLE);

    // Scan divider, row drive, snapshot and frame debounce tracking
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            row_idx    <= '0;
            row        <= {{(ROWS-1){1'b0}}, 1'b1};
            snap       <= '0;
            prev       <= '0;
            stable_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                snap    <= snap_nxt;
                row_idx <= row_idx_nxt;
                row     <= row_nxt;
            end
            if (frame_end) begin
                stable_cnt <= stable_nxt;
                if (snap_nxt != prev) prev <= snap_nxt;
            end
        end
    end

    // Emitter FSM: commit the debounced frame, then walk every key index once
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            emit_idx  <= '0;
            key_state <= '0;
            diff      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        key_state <= snap_nxt;
                        diff      <= snap_nxt ^ key_state;
                        emit_idx  <= '0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (emit_idx == KW'(N - 1)) begin
                        emit_idx <= '0;
                        state    <= IDLE;
                    end else begin
                        emit_idx <= emit_idx + KW'(1);
                    end
                end
            endcase
        end
    end

    assign push      = (state == EMIT) && diff[emit_idx];
    assign full      = (count == CW'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // FIFO storage; contents are masked at the output while empty
    always_ff @(posedge clk_50) begin
        if (push_ok) mem[wptr] <= {emit_idx, key_state[emit_idx]};
    end

    assign {evt_code, evt_press} = evt_valid ? mem[rptr] : '0;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed vector table plus hand-written
// sequences for latency, overflow and reset-during-emit.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SCAN_DIV = 4;
    localparam int DF = 3;
    localparam int FD = 4;
    localparam int KW = 4;
    localparam logic [4:0] Z = 5'd0;

    logic            clk_50 = 1'b0;
    logic            rst = 1'b1;
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic [15:0]     key_state;
    logic            evt_valid;
    logic            evt_ready = 1'b1;
    logic [KW-1:0]   evt_code;
    logic            evt_press;
    logic            overflow;
    logic            ovf_clr = 1'b0;
    logic [15:0]     keys = '0;

    int n_tests = 0;
    int n_fail = 0;
    logic [4:0] evq [$];

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic [15:0] st;
        int          n;
        logic [14:0] ev;
    } vec_t;

    vec_t vt [9];

    keypad_matrix_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_FRAMES(DF),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_50(clk_50),
        .rst(rst),
        .col(col),
        .row(row),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_press(evt_press),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk_50 = ~clk_50;

    // Keypad model: a closed key connects its row line to its column line
    always_comb begin
        col = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row[r] && keys[r*COLS + c]) col[c] = 1'b1;
    end

    // Record every accepted event ({code, press})
    always @(negedge clk_50) begin
        if (!rst && evt_valid && evt_ready) evq.push_back({evt_code, evt_press});
    end

    function automatic logic [4:0] E(input logic [3:0] code, input logic p);
        return {code, p};
    endfunction

    function automatic logic [14:0] ev3(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        logic [4:0] exp_ov [4];

        vt[0] = '{keys:16'h0000, hold:60,  st:16'h0000, n:0, ev:ev3(Z, Z, Z)};
        vt[1] = '{keys:16'h0040, hold:120, st:16'h0040, n:1, ev:ev3(E(6, 1), Z, Z)};
        vt[2] = '{keys:16'h0000, hold:120, st:16'h0000, n:1, ev:ev3(E(6, 0), Z, Z)};
        vt[3] = '{keys:16'h0040, hold:32,  st:16'h0000, n:0, ev:ev3(Z, Z, Z)};
        vt[4] = '{keys:16'h0000, hold:120, st:16'h0000, n:0, ev:ev3(Z, Z, Z)};
        vt[5] = '{keys:16'h0040, hold:48,  st:16'h0000, n:0, ev:ev3(Z, Z, Z)};
        vt[6] = '{keys:16'h0000, hold:120, st:16'h0000, n:0, ev:ev3(Z, Z, Z)};
        vt[7] = '{keys:16'h4202, hold:120, st:16'h4202, n:3,
                  ev:ev3(E(1, 1), E(9, 1), E(14, 1))};
        vt[8] = '{keys:16'h0000, hold:120, st:16'h0000, n:3,
                  ev:ev3(E(1, 0), E(9, 0), E(14, 0))};

        exp_ov[0] = E(0, 1);
        exp_ov[1] = E(3, 1);
        exp_ov[2] = E(5, 1);
        exp_ov[3] = E(10, 1);

        // reset state
        repeat (3) @(posedge clk_50);
        #1;
        check("rst_row", row, 1);
        check("rst_key_state", key_state, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_code", evt_code, 0);
        check("rst_evt_press", evt_press, 0);
        check("rst_overflow", overflow, 0);

        // row sequence, each row held SCAN_DIV cycles
        rst = 1'b0;
        for (int k = 0; k < 2*ROWS; k++)
            for (int j = 0; j < SCAN_DIV; j++) begin
                @(negedge clk_50);
                check($sformatf("row_seq_%0d_%0d", k, j), row, 32'd1 << (k % ROWS));
                check("idle_valid", evt_valid, 0);
            end
        @(posedge clk_50);
        #1;

        // vector table
        for (int v = 0; v < 9; v++) begin
            evq.delete();
            keys = vt[v].keys;
            repeat (vt[v].hold) @(posedge clk_50);
            #1;
            check($sformatf("v%0d_state", v), key_state, vt[v].st);
            check($sformatf("v%0d_nevt", v), evq.size(), vt[v].n);
            for (int i = 0; i < vt[v].n; i++)
                if (i < evq.size())
                    check($sformatf("v%0d_evt%0d", v, i), evq[i], vt[v].ev[i*5 +: 5]);
        end

        // commit-to-valid latency for key 6
        evq.delete();
        evt_ready = 1'b0;
        keys = 16'h0040;
        n = 0;
        while (!key_state[6] && n < 200) begin
            @(negedge clk_50);
            n++;
        end
        check("commit_seen", key_state[6], 1);
        n = 0;
        while (!evt_valid && n < 40) begin
            @(negedge clk_50);
            n++;
        end
        check("evt_latency", n, 7);
        check("lat_code", evt_code, 6);
        check("lat_press", evt_press, 1);
        #1 evt_ready = 1'b1;
        repeat (2) @(posedge clk_50);
        #1;
        keys = 16'h0000;
        repeat (120) @(posedge clk_50);
        #1;
        check("lat_rel_state", key_state, 0);

        // overflow: five changes into a four-entry FIFO
        evq.delete();
        evt_ready = 1'b0;
        keys = 16'h8429;
        repeat (120) @(posedge clk_50);
        #1;
        check("ovf_state", key_state, 32'h8429);
        check("ovf_valid", evt_valid, 1);
        check("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        @(posedge clk_50);
        #1;
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        evt_ready = 1'b1;
        repeat (10) @(posedge clk_50);
        #1;
        check("ovf_ndrain", evq.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < evq.size())
                check($sformatf("ovf_drain%0d", i), evq[i], exp_ov[i]);
        check("ovf_empty", evt_valid, 0);
        evq.delete();
        keys = 16'h0000;
        repeat (120) @(posedge clk_50);
        #1;
        check("rel5_nevt", evq.size(), 5);
        check("rel5_ovf", overflow, 0);
        check("rel5_state", key_state, 0);

        // reset while emitting with two events queued
        evq.delete();
        evt_ready = 1'b0;
        keys = 16'h000C;
        n = 0;
        while (!evt_valid && n < 200) begin
            @(negedge clk_50);
            n++;
        end
        check("emit_start", evt_valid, 1);
        @(posedge clk_50);
        #1;
        check("pre_rst_valid", evt_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_state", key_state, 0);
        check("mid_rst_row", row, 1);
        @(posedge clk_50);
        #1;
        rst = 1'b0;
        check("post_rst_row0", row, 1);
        repeat (SCAN_DIV) @(posedge clk_50);
        #1;
        check("post_rst_row1", row, 2);
        evt_ready = 1'b1;
        repeat (120) @(posedge clk_50);
        #1;
        check("resume_state", key_state, 32'h000C);
        check("resume_nevt", evq.size(), 2);
        if (evq.size() >= 2) begin
            check("resume_evt0", evq[0], E(2, 1));
            check("resume_evt1", evq[1], E(3, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
